// File: rtl/arq_rx_ctrl.sv
// arq_rx_ctrl: receive-side ARQ sequencer.
// Judges each frame from its CRC result and ARQ flag, then accepts it,
// NACKs it for retransmission, or drops it. Responses go out on a
// valid/ready ACK/NACK channel. A timeout and a retry limit supervise
// each retransmission. All outputs are registered.
// Optional build macro: ARQ_RX_STATS_EN adds saturating NACK/drop/timeout
// event counters.
module arq_rx_ctrl #(
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 8192,
    parameter int TMR_W       = 14
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_start,
    input  logic        i_arq_en,
    input  logic        i_arq_en_valid,
    input  logic        i_crc_err,
    input  logic        i_crc_err_valid,
    output logic        o_resp_valid,
    output logic        o_resp_nack,
    input  logic        i_resp_ready,
    output logic        o_frame_good,
    output logic        o_frame_drop,
    output logic        o_timeout,
    output logic        o_sync_err,
    output logic [3:0]  o_retry_cnt,
`ifdef ARQ_RX_STATS_EN
    output logic [15:0] o_nack_total,
    output logic [15:0] o_drop_total,
    output logic [15:0] o_tmo_total,
`endif
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_CRC  = 3'd1,
        S_SEND_ACK  = 3'd2,
        S_SEND_NACK = 3'd3,
        S_WAIT_RETX = 3'd4,
        S_DROP      = 3'd5
    } state_t;

    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(0);

    state_t             state_q, state_d;
    logic               arq_q, arq_d;
    logic [3:0]         retry_q, retry_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pend_q, pend_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_nack_q, resp_nack_d;
    logic               good_q, good_d;
    logic               drop_q, drop_d;
    logic               tmo_q, tmo_d;
    logic               sync_q, sync_d;
    logic               busy_q, busy_d;
    logic               start_any_s;
    logic               arq_eff_s;
    logic               nack_hs_s;

    assign start_any_s = i_frame_start | pend_q;
    // A qualifier arriving with the CRC result overrides the latched flag.
    assign arq_eff_s   = i_arq_en_valid ? i_arq_en : arq_q;

    // Next-state, counter and output-pulse decisions.
    always_comb begin
        state_d   = state_q;
        arq_d     = arq_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        pend_d    = pend_q;
        good_d    = 1'b0;
        drop_d    = 1'b0;
        tmo_d     = 1'b0;
        sync_d    = 1'b0;
        nack_hs_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_any_s) begin
                    state_d = S_WAIT_CRC;
                    arq_d   = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_CRC: begin
                if (i_crc_err_valid) begin
                    // A start alongside the result belongs to the next frame.
                    if (i_frame_start) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
                    arq_d = arq_eff_s;
                    if (!arq_eff_s) begin
                        good_d  = ~i_crc_err;
                        drop_d  = i_crc_err;
                        retry_d = 4'd0;
                        state_d = S_IDLE;
                    end else if (!i_crc_err) begin
                        state_d = S_SEND_ACK;
                    end else if (retry_q < MAX_R) begin
                        state_d = S_SEND_NACK;
                    end else begin
                        state_d = S_DROP;
                        drop_d  = 1'b1;
                    end
                end else if (i_frame_start) begin
                    // New frame began before the previous one was judged.
                    sync_d = 1'b1;
                    arq_d  = i_arq_en_valid ? i_arq_en : 1'b0;
                end else begin
                    arq_d = arq_eff_s;
                end
            end
            S_SEND_ACK: begin
                if (i_frame_start) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (resp_valid_q && i_resp_ready) begin
                    good_d  = 1'b1;
                    retry_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEND_ACK;
                end
            end
            S_SEND_NACK: begin
                if (i_frame_start) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (resp_valid_q && i_resp_ready) begin
                    nack_hs_s = 1'b1;
                    retry_d   = (retry_q < MAX_R) ? (retry_q + 4'd1) : retry_q;
                    timer_d   = TMR_LOAD;
                    state_d   = S_WAIT_RETX;
                end else begin
                    state_d = S_SEND_NACK;
                end
            end
            S_WAIT_RETX: begin
                if (start_any_s) begin
                    state_d = S_WAIT_CRC;
                    arq_d   = 1'b0;
                    pend_d  = 1'b0;
                end else if (timer_q == TMR_ZERO) begin
                    tmo_d = 1'b1;
                    if (retry_q < MAX_R) begin
                        state_d = S_SEND_NACK;
                    end else begin
                        state_d = S_DROP;
                        drop_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_DROP: begin
                if (i_frame_start) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                retry_d = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        resp_valid_d = (state_d == S_SEND_ACK) || (state_d == S_SEND_NACK);
        resp_nack_d  = (state_d == S_SEND_NACK);
        busy_d       = (state_d != S_IDLE);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            arq_q        <= 1'b0;
            retry_q      <= 4'd0;
            timer_q      <= TMR_ZERO;
            pend_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_nack_q  <= 1'b0;
            good_q       <= 1'b0;
            drop_q       <= 1'b0;
            tmo_q        <= 1'b0;
            sync_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            arq_q        <= arq_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
            resp_valid_q <= resp_valid_d;
            resp_nack_q  <= resp_nack_d;
            good_q       <= good_d;
            drop_q       <= drop_d;
            tmo_q        <= tmo_d;
            sync_q       <= sync_d;
            busy_q       <= busy_d;
        end
    end

    assign o_resp_valid = resp_valid_q;
    assign o_resp_nack  = resp_nack_q;
    assign o_frame_good = good_q;
    assign o_frame_drop = drop_q;
    assign o_timeout    = tmo_q;
    assign o_sync_err   = sync_q;
    assign o_retry_cnt  = retry_q;
    assign o_busy       = busy_q;

`ifdef ARQ_RX_STATS_EN
    logic [15:0] nack_tot_q, nack_tot_d;
    logic [15:0] drop_tot_q, drop_tot_d;
    logic [15:0] tmo_tot_q,  tmo_tot_d;

    // Saturating event counters, stepped alongside the matching pulse.
    always_comb begin
        nack_tot_d = nack_tot_q + ((nack_hs_s && (nack_tot_q != 16'hFFFF)) ? 16'd1 : 16'd0);
        drop_tot_d = drop_tot_q + ((drop_d && (drop_tot_q != 16'hFFFF)) ? 16'd1 : 16'd0);
        tmo_tot_d  = tmo_tot_q  + ((tmo_d  && (tmo_tot_q  != 16'hFFFF)) ? 16'd1 : 16'd0);
    end

    // Event counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            nack_tot_q <= 16'd0;
            drop_tot_q <= 16'd0;
            tmo_tot_q  <= 16'd0;
        end else begin
            nack_tot_q <= nack_tot_d;
            drop_tot_q <= drop_tot_d;
            tmo_tot_q  <= tmo_tot_d;
        end
    end

    assign o_nack_total = nack_tot_q;
    assign o_drop_total = drop_tot_q;
    assign o_tmo_total  = tmo_tot_q;
`endif

endmodule
